// File: rtl/jpeg_dec_pkg.sv
// Shared JPEG decoder definitions: widths, the zigzag-to-natural map, the block type
// and the dequantization arithmetic.
package jpeg_dec_pkg;

   localparam int unsigned NUM_QT   = 4;
   localparam int unsigned COEF_W   = 12;
   localparam int unsigned Q_W      = 8;
   localparam int unsigned QT_SEL_W = $clog2(NUM_QT);
   localparam int unsigned POS_W    = 6;
   localparam int unsigned NUM_COEF = 64;
   localparam int unsigned PROD_W   = COEF_W + Q_W + 1;

   localparam int COEF_MAX = (1 << (COEF_W - 1)) - 1;
   localparam int COEF_MIN = -(1 << (COEF_W - 1));

   // Natural index (row*8+col) of each zigzag position.
   localparam logic [POS_W-1:0] ZZ_TO_NAT [NUM_COEF] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   typedef logic signed [COEF_W-1:0] blk_t [7:0][7:0];

   typedef enum logic {ST_IDLE, ST_FILL} state_t;

   // Signed coefficient times zero-extended table entry; the width holds the exact product.
   function automatic logic signed [PROD_W-1:0] dequant_mul(
      input logic signed [COEF_W-1:0] c,
      input logic        [Q_W-1:0]    q
   );
      logic signed [Q_W:0] qs;
      qs = $signed({1'b0, q});
      return PROD_W'(c) * PROD_W'(qs);
   endfunction

   function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [PROD_W-1:0] p);
      logic signed [PROD_W-1:0] hi;
      logic signed [PROD_W-1:0] lo;
      logic signed [COEF_W-1:0] r;
      hi = PROD_W'(COEF_MAX);
      lo = PROD_W'(COEF_MIN);
      if (p > hi)      r = COEF_W'(hi);
      else if (p < lo) r = COEF_W'(lo);
      else             r = COEF_W'(p);
      return r;
   endfunction

endpackage

// File: rtl/qt_store.sv
// Quantization table register file: NUM_QT tables of 64 entries, async read,
// synchronous write, every entry resets to 1.
module qt_store
   import jpeg_dec_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [QT_SEL_W-1:0] wr_sel,
   input  logic [POS_W-1:0]    wr_addr,
   input  logic [Q_W-1:0]      wr_data,
   input  logic [QT_SEL_W-1:0] rd_sel,
   input  logic [POS_W-1:0]    rd_addr,
   output logic [Q_W-1:0]      rd_data
);

   logic [Q_W-1:0] mem [NUM_QT][NUM_COEF];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int t = 0; t < NUM_QT; t++) begin
            for (int a = 0; a < NUM_COEF; a++) begin
               mem[t][a] <= Q_W'(1);
            end
         end
      end else if (wr_en) begin
         mem[wr_sel][wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_sel][rd_addr];

endmodule

// File: rtl/dequant_dezigzag.sv
// Dequantizes zigzag-ordered coefficients and assembles them into a natural-order
// 8x8 block, presented with a one-cycle valid on the block's last beat.
module dequant_dezigzag
   import jpeg_dec_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     coef_valid,
   output logic                     coef_ready,
   input  logic signed [COEF_W-1:0] coef_data,
   input  logic                     coef_eob,
   input  logic [QT_SEL_W-1:0]      coef_qt_sel,
   input  logic                     qt_wr_en,
   input  logic [QT_SEL_W-1:0]      qt_wr_sel,
   input  logic [POS_W-1:0]         qt_wr_addr,
   input  logic [Q_W-1:0]           qt_wr_data,
   output logic                     busy,
   output blk_t                     blk_out,
   output logic                     blk_valid
);

   state_t                   state;
   logic [POS_W-1:0]         pos;
   logic [QT_SEL_W-1:0]      cur_qt;
   logic [NUM_COEF-1:0]      wmask;
   logic signed [COEF_W-1:0] coef_buf [NUM_COEF];

   logic                     is_idle;
   logic                     accept;
   logic                     emit;
   logic                     tbl_we;
   logic [QT_SEL_W-1:0]      rd_sel;
   logic [Q_W-1:0]           q_entry;
   logic [POS_W-1:0]         nat;
   logic signed [COEF_W-1:0] product;

   // Table writes only win the port while no block is in flight.
   assign is_idle    = (state == ST_IDLE);
   assign coef_ready = !(is_idle && qt_wr_en);
   assign accept     = coef_valid && coef_ready;
   assign emit       = accept && (coef_eob || (pos == POS_W'(NUM_COEF - 1)));
   assign tbl_we     = qt_wr_en && is_idle;
   assign busy       = (state == ST_FILL);

   // The first beat of a block reads the table it is selecting, before cur_qt is loaded.
   assign rd_sel  = is_idle ? coef_qt_sel : cur_qt;
   assign nat     = ZZ_TO_NAT[pos];
   assign product = sat_coef(dequant_mul(coef_data, q_entry));

   qt_store u_qt_store (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (tbl_we),
      .wr_sel  (qt_wr_sel),
      .wr_addr (qt_wr_addr),
      .wr_data (qt_wr_data),
      .rd_sel  (rd_sel),
      .rd_addr (pos),
      .rd_data (q_entry)
   );

   // Block FSM, write mask and the registered output block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         pos       <= '0;
         cur_qt    <= '0;
         wmask     <= '0;
         blk_valid <= 1'b0;
         for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
               blk_out[r][c] <= '0;
            end
         end
      end else begin
         blk_valid <= 1'b0;
         if (accept) begin
            if (is_idle) cur_qt <= coef_qt_sel;
            if (emit) begin
               state     <= ST_IDLE;
               pos       <= '0;
               wmask     <= '0;
               blk_valid <= 1'b1;
               for (int n = 0; n < NUM_COEF; n++) begin
                  if (POS_W'(n) == nat)  blk_out[n / 8][n % 8] <= product;
                  else if (wmask[n])     blk_out[n / 8][n % 8] <= coef_buf[n];
                  else                   blk_out[n / 8][n % 8] <= '0;
               end
            end else begin
               state      <= ST_FILL;
               pos        <= pos + POS_W'(1);
               wmask[nat] <= 1'b1;
            end
         end
      end
   end

   // Coefficient store; stale contents are masked by wmask, so no reset.
   always_ff @(posedge clk) begin
      if (accept) coef_buf[nat] <= product;
   end

endmodule
